// File: rtl/matrix_pkg.sv
// +----------------------------------------------------------------------------+
// | matrix_pkg : shared matrix geometry and serializer FSM encodings           |
// | Rev 1.0    : initial release                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package matrix_pkg;

  localparam int MAT_DATA_W   = 8;
  localparam int MAT_NUM_ELEM = 12;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/ser_idx_counter.sv
// +----------------------------------------------------------------------------+
// | ser_idx_counter : saturating element index counter, 0 .. NUM_ELEM-1        |
// | Rev 1.0         : initial release                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module ser_idx_counter #(
  parameter int NUM_ELEM = 12,
  parameter int IDX_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [IDX_W-1:0] idx,
  output logic             at_last
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEM - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (inc && !at_last) begin
      idx <= idx + 1'b1;
    end
  end

  assign at_last = (idx == LAST_IDX);

endmodule

`default_nettype wire

// File: rtl/matrix_serializer.sv
// +----------------------------------------------------------------------------+
// | matrix_serializer : parallel-load matrix, stream elements with index tags  |
// | Optional MATRIX_SER_LAST_EN adds last_out, flagging the final beat.        |
// | Rev 1.0           : initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module matrix_serializer
  import matrix_pkg::*;
#(
  parameter int DATA_W   = MAT_DATA_W,
  parameter int NUM_ELEM = MAT_NUM_ELEM,
  parameter int IDX_W    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load,
  input  logic [NUM_ELEM*DATA_W-1:0] data_in,
  output logic [DATA_W-1:0]          data_out,
  output logic [IDX_W-1:0]           sel_out,
  output logic                       valid_out,
  input  logic                       ready_in,
  output logic                       busy,
  output logic                       done
`ifdef MATRIX_SER_LAST_EN
  ,
  output logic                       last_out
`endif
);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [DATA_W-1:0] shadow [NUM_ELEM];
  logic [IDX_W-1:0]  idx;
  logic              at_last;
  logic              capture;
  logic              accept;
  logic              last_accept;

  assign capture     = (state == ST_IDLE) && load;
  assign accept      = valid_out && ready_in;
  assign last_accept = accept && at_last;

  // Clearing on the final beat leaves idx at 0 throughout DONE.
  ser_idx_counter #(
    .NUM_ELEM (NUM_ELEM),
    .IDX_W    (IDX_W)
  ) u_idx_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (capture || last_accept),
    .inc     (accept),
    .idx     (idx),
    .at_last (at_last)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (load)        state_nxt = ST_SEND;
      ST_SEND: if (last_accept) state_nxt = ST_DONE;
      ST_DONE:                  state_nxt = ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_ELEM; k++) shadow[k] <= '0;
    end else if (capture) begin
      for (int k = 0; k < NUM_ELEM; k++) shadow[k] <= data_in[k*DATA_W +: DATA_W];
    end
  end

  assign valid_out = (state == ST_SEND);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign sel_out   = idx;
  assign data_out  = valid_out ? shadow[idx] : '0;

`ifdef MATRIX_SER_LAST_EN
  assign last_out  = valid_out && at_last;
`endif

endmodule

`default_nettype wire

// File: tb/tb_matrix_serializer.sv
// +----------------------------------------------------------------------------+
// | tb_matrix_serializer : directed self-checking bench for matrix_serializer  |
// | Rev 1.0              : initial release                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_matrix_serializer;

  localparam int DW = 8;
  localparam int NE = 12;
  localparam int IW = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           load;
  logic [NE*DW-1:0] data_in;
  logic [DW-1:0]  data_out;
  logic [IW-1:0]  sel_out;
  logic           valid_out;
  logic           ready_in;
  logic           busy;
  logic           done;
  logic           last_out;

  logic [DW-1:0]  exp_mem [NE];
  int             checks = 0;
  int             errors = 0;

  always #5 clk = ~clk;

  matrix_serializer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .data_in   (data_in),
    .data_out  (data_out),
    .sel_out   (sel_out),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .busy      (busy),
    .done      (done)
`ifdef MATRIX_SER_LAST_EN
    ,
    .last_out  (last_out)
`endif
  );

`ifndef MATRIX_SER_LAST_EN
  assign last_out = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // Sets data_in and the expected element table together.
  task automatic set_vec(input logic [DW-1:0] base, input bit same);
    for (int k = 0; k < NE; k++) begin
      exp_mem[k] = same ? base : base + DW'(k);
      data_in[k*DW +: DW] = exp_mem[k];
    end
  endtask

  task automatic check_beat(input int k);
    check("valid", valid_out, 1);
    check("sel", sel_out, k);
    check("data", data_out, exp_mem[k]);
    check("busy", busy, 1);
    check("done_low", done, 0);
`ifdef MATRIX_SER_LAST_EN
    check("last", last_out, (k == NE - 1) ? 1 : 0);
`endif
  endtask

  task automatic stream_beats(input int from, input int to, input int stall_idx, input int stall_len);
    for (int k = from; k <= to; k++) begin
      if (k == stall_idx) begin
        ready_in = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          check_beat(k);
          tick();
        end
        ready_in = 1'b1;
      end
      check_beat(k);
      tick();
    end
  endtask

  task automatic check_done_then_idle;
    check("done_pulse", done, 1);
    check("done_busy", busy, 1);
    check("done_valid", valid_out, 0);
    check("done_sel", sel_out, 0);
    check("done_data", data_out, 0);
`ifdef MATRIX_SER_LAST_EN
    check("done_last", last_out, 0);
`endif
    tick();
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
    check("idle_valid", valid_out, 0);
    check("idle_data", data_out, 0);
  endtask

  task automatic do_load;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    load     = 1'b0;
    ready_in = 1'b1;
    data_in  = '0;
    tick();
    tick();
    check("rst_data", data_out, 0);
    check("rst_sel", sel_out, 0);
    check("rst_valid", valid_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_last", last_out, 0);
    rst_n = 1'b1;
    tick();

    // Basic stream: first beat one cycle after the load edge, done 13 cycles after it.
    set_vec(8'h10, 1'b0);
    do_load();
    stream_beats(0, NE - 1, -1, 0);
    check_done_then_idle();
    tick();
    check("idle_hold_valid", valid_out, 0);

    // Backpressure at idx 4, plus a stalled final beat.
    do_load();
    stream_beats(0, 10, 4, 5);
    stream_beats(11, 11, 11, 3);
    check_done_then_idle();

    // Load while busy is ignored; load on the done cycle is ignored too.
    set_vec(8'h10, 1'b0);
    do_load();
    stream_beats(0, 5, -1, 0);
    set_vec(8'hAA, 1'b1);
    for (int k = 0; k < NE; k++) exp_mem[k] = 8'h10 + DW'(k);
    load = 1'b1;
    check_beat(6);
    tick();
    load = 1'b0;
    stream_beats(7, NE - 1, -1, 0);
    load = 1'b1;
    check("done_w_load", done, 1);
    tick();
    load = 1'b0;
    check("load_on_done_ignored", valid_out, 0);
    check("load_on_done_busy", busy, 0);
    set_vec(8'hAA, 1'b1);
    do_load();
    stream_beats(0, NE - 1, -1, 0);
    check_done_then_idle();

    // Asynchronous reset mid-stream at idx 8.
    set_vec(8'h10, 1'b0);
    do_load();
    stream_beats(0, 7, -1, 0);
    check("pre_rst_sel", sel_out, 8);
    rst_n = 1'b0;
    #1;
    check("arst_data", data_out, 0);
    check("arst_sel", sel_out, 0);
    check("arst_valid", valid_out, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_last", last_out, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_done", done, 0);
    check("post_rst_busy", busy, 0);
    set_vec(8'h30, 1'b0);
    do_load();
    stream_beats(0, NE - 1, 11, 2);
    check_done_then_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
